// File: rtl/dff_chain_ctrl.sv
// dff_chain_ctrl: sequences a serial chain of WIDTH D flip-flops.
// A parallel word accepted on in_valid/in_ready is shifted LSB first into
// the chain. The bits coming out of the last stage are captured at the same
// time and returned on out_valid/out_ready as the chain's previous contents.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  word handshake from the requester, data on in_data
//   chain_en, chain_d  shift enable and serial data into chain stage 0
//   chain_q            serial data from the last chain stage
//   out_valid/ready    captured word handshake, data on out_data
//   busy               high while shifting or holding a result
//   out_parity         XOR of the captured word (only with DFF_CHAIN_PARITY_EN)
//
// Optional feature macro: DFF_CHAIN_PARITY_EN
module dff_chain_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             chain_en,
  output logic             chain_d,
  input  logic             chain_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef DFF_CHAIN_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   cap_q, cap_d;
  logic [WIDTH-1:0]   cap_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, chain_en_q, out_valid_q, busy_q;
`ifdef DFF_CHAIN_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Capture register with the bit leaving the chain entering at the top.
  assign cap_shift = {chain_q, cap_q[WIDTH-1:1]};

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
`ifdef DFF_CHAIN_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cap_d   = cap_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef DFF_CHAIN_PARITY_EN
          parity_d = ^cap_shift;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cap_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      chain_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DFF_CHAIN_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      chain_en_q  <= (state_d == SHIFT);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
`ifdef DFF_CHAIN_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign chain_en  = chain_en_q;
  assign chain_d   = shreg_q[0];
  assign out_valid = out_valid_q;
  assign out_data  = cap_q;
  assign busy      = busy_q;
`ifdef DFF_CHAIN_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: doc/dff_chain_ctrl.md
Name: dff_chain_ctrl

Overview:
- Controller that sequences a serial chain of WIDTH D flip-flops (scan/shift chain).
- Accepts a parallel word on a valid/ready input and shifts it serially into the chain, LSB first.
- While shifting, it captures the chain's previous contents from the chain's last stage and returns them as a parallel word on a valid/ready output.
- Sits between a register-level requester and a bank of flip-flop cells that share one clock.

Parameters:
- WIDTH, 8, number of flip-flop stages in the chain and width of the data words (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the internal shift counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  requester presents in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to load into the chain.
- chain_en  output  1  shift enable for every flip-flop in the chain.
- chain_d  output  1  serial data into chain stage 0.
- chain_q  input  1  serial data from the last chain stage.
- out_valid  output  1  captured word available.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  previous chain contents; the first bit shifted out is at bit 0.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset and synchronicity:
  - Reset is synchronous and active-high on clk; one clock, no other clock domains.
  - rst high at an edge: state=IDLE, shift register=0, capture register=0, counter=0.
  - From the following cycle: in_ready=1, out_valid=0, out_data=0, chain_en=0, chain_d=0, busy=0.
  - rst has priority over every other event.
- IDLE:
  - in_ready=1, chain_en=0, chain_d=0.
  - in_valid & in_ready at an edge: shreg<=in_data, cnt<=0, state<=SHIFT.
- SHIFT:
  - in_ready=0, chain_en=1, chain_d=shreg[0] (combinational from the register).
  - Each edge: shreg<=shreg>>1; cap<={chain_q, cap[WIDTH-1:1]}; cnt<=cnt+1.
  - The edge on which cnt==WIDTH-1 is the last shift; state<=DONE.
  - Exactly WIDTH cycles with chain_en=1 per transaction.
- DONE:
  - chain_en=0, out_valid=1, out_data=cap; both are held stable until out_ready.
  - out_valid & out_ready at an edge: state<=IDLE.
  - in_ready returns to 1 in the next cycle. There is no same-cycle accept from DONE.
- Latency:
  - Accept edge E0; shift edges E1..EWIDTH; out_valid high in the cycle after EWIDTH.
  - With WIDTH=8, out_valid rises 8 cycles after E0.
- Boundary conditions:
  - in_valid while SHIFT or DONE is ignored and in_data is not sampled.
  - out_ready while not DONE has no effect.
  - Reset mid-SHIFT aborts the transaction: chain_en drops the cycle after the reset edge.
  - Chain contents are left partially shifted and are not restored; no out_valid is produced for the aborted transaction.
  - The counter never wraps: it is cleared on every accept.
- Chain contract:
  - The chain is WIDTH stages.
  - Stage i+1 samples stage i on the rising edge of clk when chain_en=1.
  - chain_q is stage WIDTH-1 output, sampled by the controller at the same edge it shifts.

Optional Feature:
- DFF_CHAIN_PARITY_EN defined:
  - Adds output out_parity (1 bit) = XOR of all bits of cap.
  - Registered together with the last capture edge, valid with out_valid, held in DONE.
  - 0 after reset.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 2 cycles, release -> in_ready=1, out_valid=0, out_data=0, chain_en=0, busy=0.
- Load sequence: WIDTH=8, bench models an 8-DFF chain; load 0x00, then 0xA5, then 0x3C.
  - Second transaction drives chain_d = 1,0,1,0,0,1,0,1 over 8 cycles and returns out_data=0x00.
  - Third transaction returns out_data=0xA5.
- Latency: accept 0x5A at edge E0 -> chain_en high for exactly 8 cycles, out_valid first high after E8, busy high from the cycle after E0 until the return to IDLE.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE -> out_valid=1 and out_data constant, in_ready=0, chain_en=0.
  - Then out_ready=1 for one cycle -> in_ready=1 next cycle.
- Ignored input: pulse in_valid with in_data=0x11 during SHIFT -> no effect; the chain still receives the original word and the next captured word matches it.
- Reset mid-shift: rst after 3 shift edges -> next cycle chain_en=0, in_ready=1, out_valid=0.
  - A following load of 0xFF completes normally in 8 shifts.
  - With DFF_CHAIN_PARITY_EN, capture of 0xA5 gives out_parity=0 and capture of 0x07 gives out_parity=1.
